// File: rtl/stage_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// stage_pipe_ctrl
//   Valid/ready controller for a chain of STAGES pipeline data registers.
//   It keeps one valid bit per stage. Each stage is ready when it is empty
//   or when the stage after it is ready. Bubbles therefore collapse, and a
//   full pipe can accept and emit in the same cycle.
//
//   Parameters
//     STAGES     number of stitched register stages (1..16)
//     CW         occupancy count width
//
//   Ports
//     clk        sole clock, rising edge
//     rst_n      asynchronous active-low reset (release synchronised outside)
//     in_valid   upstream offers a datum
//     in_ready   a datum is taken into stage 1 this cycle
//     out_valid  the last stage holds a valid result
//     out_ready  downstream consumes the result this cycle
//     flush      discards all in-flight data on the next edge
//     stage_en   bit k-1 is the load enable of data register p_k
//     occupancy  registered count of valid stages
//     idle       high when occupancy is 0
//
//   Optional feature
//     Define STAGE_PIPE_CTRL_PERF_EN to add the 32-bit counters
//     perf_in_cnt, perf_out_cnt and perf_stall_cnt. Only rst_n clears them.
// ---------------------------------------------------------------------------
module stage_pipe_ctrl #(
    parameter int STAGES = 2,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [CW-1:0]     occupancy,
    output logic              idle
`ifdef STAGE_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_in_cnt,
    output logic [31:0]       perf_out_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic [STAGES:1]   valid_reg;
    logic [STAGES:1]   valid_next;
    logic [STAGES+1:1] rdy;
    logic [STAGES:0]   src_valid;
    logic [CW-1:0]     occ_reg;
    logic [CW-1:0]     occ_next;

    // Index 0 stands for the upstream offer. Stage k takes its data from k-1.
    assign src_valid = {valid_reg, in_valid};

    // Compute the ready chain from the output end backwards in one process.
    always_comb begin
        rdy = '0;
        rdy[STAGES+1] = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            rdy[k] = !valid_reg[k] || rdy[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_stage
            // A load enable is only raised when the source holds valid data.
            assign stage_en[gi-1]  = rdy[gi] && src_valid[gi-1] && !flush;
            // Flush wins over every transfer.
            assign valid_next[gi]  = flush   ? 1'b0 :
                                     rdy[gi] ? src_valid[gi-1] : valid_reg[gi];
        end
    endgenerate

    // The count is taken from the next-state vector, so the registered value
    // always matches the valid bits it describes.
    always_comb begin
        occ_next = '0;
        for (int k = 1; k <= STAGES; k++) begin
            occ_next = occ_next + CW'(valid_next[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            occ_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            occ_reg   <= occ_next;
        end
    end

    assign in_ready  = rdy[1] && !flush;
    assign out_valid = valid_reg[STAGES] && !flush;
    assign occupancy = occ_reg;
    assign idle      = (occ_reg == '0);

`ifdef STAGE_PIPE_CTRL_PERF_EN
    logic [31:0] perf_in_reg;
    logic [31:0] perf_out_reg;
    logic [31:0] perf_stall_reg;

    // Flush does not clear these counters. They wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_in_reg    <= '0;
            perf_out_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (in_valid && in_ready)
                perf_in_reg <= perf_in_reg + 32'd1;
            if (out_valid && out_ready)
                perf_out_reg <= perf_out_reg + 32'd1;
            if (out_valid && !out_ready)
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_in_cnt    = perf_in_reg;
    assign perf_out_cnt   = perf_out_reg;
    assign perf_stall_cnt = perf_stall_reg;
`endif

endmodule
